// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
//   Shared definitions for the HI/LO multiply/divide unit of the MIPS core.
//   Holds the MD operation codes used by the EX-stage decode and by
//   muldiv_unit, plus small classification helpers on those codes.
//
//   Contents:
//     MD_MULT .. MD_MTLO   3-bit operation codes
//     MD_WIDTH             data width (fixed at 32)
//     is_md_op()           op starts an iterative multiply/divide
//     is_signed_op()       op treats operands as two's complement
//     is_div_op()          op is a divide (signed or unsigned)
// -----------------------------------------------------------------------------
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  function automatic logic is_md_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit owning the HI/LO register pair. Executes
//   MULT, MULTU, DIV, DIVU (33 cycles after acceptance) and MTHI/MTLO (single
//   cycle). While a computation is in flight, any new HI/LO operation or an
//   MFHI/MFLO in EX raises stall so the pipeline holds that instruction.
//
//   Datapath: one 64-bit shift register (acc) plus one 33-bit adder that
//   either adds the multiplicand (multiply) or subtracts the divisor (divide).
//   Signed operations run on magnitudes; signs are re-applied in FIX.
//
//   Ports:
//     clk      in   rising-edge clock
//     rst      in   synchronous, active-high reset
//     start    in   EX-stage request; op/a/b valid this cycle
//     op       in   [2:0] operation code (muldiv_pkg::MD_*)
//     a        in   [31:0] rs: multiplicand / dividend / MTHI-MTLO source
//     b        in   [31:0] rt: multiplier / divisor
//     hilo_rd  in   EX instruction is MFHI or MFLO
//     hi       out  [31:0] HI register
//     lo       out  [31:0] LO register
//     busy     out  multiply/divide in progress
//     done     out  one-cycle pulse after HI/LO written by MULT/DIV
//     stall    out  busy & (start | hilo_rd), combinational
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hilo_rd,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]  state;
  logic [4:0]  count;

  // Datapath registers.
  //   multiply: acc = {partial product, remaining multiplier bits}
  //   divide:   acc = {partial remainder, quotient bits shifted in}
  logic [63:0] acc;
  logic [31:0] opnd;      // multiplicand or divisor magnitude
  logic        is_div;
  logic        neg_q;     // negate product / quotient in FIX
  logic        neg_r;     // negate remainder in FIX
  logic        div_zero;

  logic        accept;
  logic        op_signed;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  logic [32:0] add_x;
  logic [32:0] add_y;
  logic        add_cin;
  logic [32:0] add_sum;
  logic        sub_ok;
  logic [63:0] acc_step;

  logic [63:0] prod;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  assign busy  = (state != S_IDLE);
  assign stall = busy & (start | hilo_rd);

  // Starts are only taken in IDLE; while busy the request is held in EX by
  // stall and re-presented once the unit drains.
  assign accept    = (state == S_IDLE) && start && is_md_op(op);
  assign op_signed = is_signed_op(op);
  assign abs_a     = (op_signed && a[31]) ? (~a + 32'd1) : a;
  assign abs_b     = (op_signed && b[31]) ? (~b + 32'd1) : b;

  // Shared 33-bit adder.
  //   multiply: {carry, hi} = acc[63:32] + multiplicand
  //   divide:   (remainder shifted left, without its bit 32) - divisor;
  //             add_sum[32] is the borrow.
  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (defaults first here), otherwise synthesis infers a latch.
  always_comb begin
    add_x   = {1'b0, acc[63:32]};
    add_y   = {1'b0, opnd};
    add_cin = 1'b0;
    if (is_div) begin
      add_x   = {1'b0, acc[62:31]};
      add_y   = ~{1'b0, opnd};
      add_cin = 1'b1;
    end
    add_sum = add_x + add_y + {32'd0, add_cin};
  end

  // One iteration of the selected algorithm.
  always_comb begin
    // The bit shifted out of the remainder (acc[63]) makes the shifted value
    // at least 2^32, which always exceeds the divisor, so subtract regardless
    // of the 33-bit borrow.
    sub_ok   = acc[63] | ~add_sum[32];
    acc_step = acc;
    if (is_div) begin
      if (sub_ok) acc_step = {add_sum[31:0], acc[30:0], 1'b1};
      else        acc_step = {acc[62:0], 1'b0};
    end else begin
      if (acc[0]) acc_step = {add_sum, acc[31:1]};
      else        acc_step = {1'b0, acc[63:1]};
    end
  end

  // Sign correction and result selection for FIX.
  always_comb begin
    prod = neg_q ? (~acc + 64'd1) : acc;
    quot = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem  = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
    // Dividing by zero leaves remainder = |a|; with the dividend's sign
    // re-applied that is exactly the original a, so only the quotient needs
    // overriding.
    if (div_zero) quot = '1;
    if (is_div) begin
      fix_hi = rem;
      fix_lo = quot;
    end else begin
      fix_hi = prod[63:32];
      fix_lo = prod[31:0];
    end
  end

  // Control state and architectural HI/LO.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      count <= 5'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (is_md_op(op)) begin
              state <= S_CALC;
              count <= 5'd0;
            end else if (op == MD_MTHI) begin
              hi <= a;
            end else if (op == MD_MTLO) begin
              lo <= a;
            end
          end
        end
        S_CALC: begin
          count <= count + 5'd1;
          if (count == 5'd31) state <= S_FIX;
        end
        S_FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand/accumulator registers.
  // NOTE: these carry no reset; they are always loaded on acceptance before
  // being used, and reset only has to return control state and HI/LO.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_div   <= is_div_op(op);
      neg_q    <= op_signed & (a[31] ^ b[31]);
      neg_r    <= op_signed & a[31];
      div_zero <= is_div_op(op) && (b == 32'd0);
      opnd     <= is_div_op(op) ? abs_b : abs_a;
      acc      <= {32'd0, (is_div_op(op) ? abs_a : abs_b)};
    end else if (state == S_CALC) begin
      acc <= acc_step;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit. Expected HI/LO values come from a
//   reference model using native 64-bit arithmetic, with the architectural
//   divide-by-zero rule applied on top.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hilo_rd;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  int n_cmp = 0;
  int n_bad = 0;

  // Architectural HI/LO as the model expects them.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .hilo_rd (hilo_rd),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done),
    .stall   (stall)
  );

  // Reference: returns {hi, lo} after op completes.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] ch,
                                        input logic [31:0] cl);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      MD_MULT:  begin q = sx * sy; p = q; return p; end
      MD_MULTU: begin p = {32'd0, x} * {32'd0, y}; return p; end
      MD_DIV: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      MD_DIVU: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
      MD_MTHI: return {x, cl};
      MD_MTLO: return {ch, x};
      default: return {ch, cl};
    endcase
  endfunction

  // Issue one operation from IDLE and check timing and result.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input string name);
    logic [63:0] e;
    int busy_cycles;
    e = model(o, x, y, m_hi, m_lo);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    if (!(o inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU})) begin
      n_cmp++;
      if ({busy, done, hi, lo} !== {2'b00, e}) begin
        n_bad++;
        $display("FAIL %s: busy=%b done=%b hi=%h lo=%h, required busy=0 done=0 hi=%h lo=%h",
                 name, busy, done, hi, lo, e[63:32], e[31:0]);
      end
      m_hi = e[63:32]; m_lo = e[31:0];
      return;
    end
    busy_cycles = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      busy_cycles++;
      @(negedge clk);
    end
    n_cmp++;
    if (busy_cycles !== 33) begin
      n_bad++;
      $display("FAIL %s busy_len: got %0d cycles, required 33", name, busy_cycles);
    end
    n_cmp++;
    if ({done, hi, lo} !== {1'b1, e}) begin
      n_bad++;
      $display("FAIL %s result: done=%b hi=%h lo=%h, required done=1 hi=%h lo=%h (a=%h b=%h)",
               name, done, hi, lo, e[63:32], e[31:0], x, y);
    end
    m_hi = e[63:32]; m_lo = e[31:0];
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done_pulse: done=%b one cycle later, required 0", name, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; hilo_rd = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({hi, lo, busy, done, stall} !== 67'd0) begin
      n_bad++;
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b stall=%b, required all 0",
               hi, lo, busy, done, stall);
    end
    rst = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  task automatic test_directed();
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
    run_op(MD_MULT,  32'hFFFFFFFD, 32'd5,        "mult_neg");
    run_op(MD_DIV,   32'hFFFFFFF9, 32'd2,        "div_neg");
    run_op(MD_DIVU,  32'd100,      32'd0,        "divu_zero");
    run_op(MD_DIV,   32'h80000000, 32'hFFFFFFFF, "div_ovf");
    run_op(MD_DIV,   32'hFFFFFFEC, 32'd0,        "div_zero_neg");
    run_op(3'd6,     32'hDEADBEEF, 32'd1,        "undef_op");
  endtask

  task automatic test_mtlo_mfhi();
    run_op(MD_MTHI, 32'hCAFEF00D, 32'd0, "mthi");
    @(negedge clk);
    start = 1'b1; op = MD_MTLO; a = 32'h1234; b = 32'd0;
    @(negedge clk);
    start = 1'b0; hilo_rd = 1'b1;
    #1;
    n_cmp++;
    if ({lo, hi, stall, busy} !== {32'h1234, 32'hCAFEF00D, 2'b00}) begin
      n_bad++;
      $display("FAIL mtlo_mflo: lo=%h hi=%h stall=%b busy=%b, required lo=00001234 hi=cafef00d 0 0",
               lo, hi, stall, busy);
    end
    hilo_rd = 1'b0;
    m_lo = 32'h1234; m_hi = 32'hCAFEF00D;
  endtask

  task automatic test_hilo_rd_stall();
    @(negedge clk);
    start = 1'b1; op = MD_MULTU; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0; hilo_rd = 1'b1;
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_hilo_rd_busy: stall=%b, required 1", stall);
    end
    hilo_rd = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_quiet_busy: stall=%b, required 0", stall);
    end
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    m_hi = 32'd0; m_lo = 32'd12;
    hilo_rd = 1'b1;
    #1;
    n_cmp++;
    if ({stall, hi, lo} !== {1'b0, 32'd0, 32'd12}) begin
      n_bad++;
      $display("FAIL stall_hilo_rd_idle: stall=%b hi=%h lo=%h, required 0 0 c", stall, hi, lo);
    end
    @(negedge clk);
    hilo_rd = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] e1, e2;
    int cyc;
    e1 = model(MD_MULT, 32'd123456, 32'hFFFFFCEB, m_hi, m_lo);
    e2 = model(MD_DIVU, 32'd9, 32'd2, e1[63:32], e1[31:0]);
    @(negedge clk);
    start = 1'b1; op = MD_MULT; a = 32'd123456; b = 32'hFFFFFCEB;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = MD_DIVU; a = 32'd9; b = 32'd2;
    for (int i = 0; i < 40 && busy; i++) begin
      #1;
      n_cmp++;
      if ({stall, hi, lo} !== {1'b1, m_hi, m_lo}) begin
        n_bad++;
        $display("FAIL b2b_hold: stall=%b hi=%h lo=%h, required 1 %h %h", stall, hi, lo, m_hi, m_lo);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({done, stall, hi, lo} !== {2'b10, e1}) begin
      n_bad++;
      $display("FAIL b2b_mult: done=%b stall=%b hi=%h lo=%h, required 1 0 %h %h",
               done, stall, hi, lo, e1[63:32], e1[31:0]);
    end
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_accept: busy=%b after start in done cycle, required 1", busy);
    end
    cyc = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      cyc++;
      @(negedge clk);
    end
    n_cmp++;
    if ({cyc, done, hi, lo} !== {32'd33, 1'b1, e2}) begin
      n_bad++;
      $display("FAIL b2b_divu: cycles=%0d done=%b hi=%h lo=%h, required 33 1 %h %h",
               cyc, done, hi, lo, e2[63:32], e2[31:0]);
    end
    m_hi = e2[63:32]; m_lo = e2[31:0];
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    @(negedge clk);
    start = 1'b1; op = MD_DIV; a = 32'hFFFFFC18; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({hi, lo, busy, done} !== 66'd0) begin
      n_bad++;
      $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b, required all 0", hi, lo, busy, done);
    end
    m_hi = 32'd0; m_lo = 32'd0;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    n_cmp++;
    if (seen_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_done: done pulsed after reset, required none");
    end
    run_op(MD_MULTU, 32'd6, 32'd7, "multu_after_rst");
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 6));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        2: y = 32'($urandom_range(1, 15));
        3: x = 32'($urandom_range(0, 255));
        default: ;
      endcase
      run_op(o, x, y, $sformatf("rand%0d_op%0d", i, o));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mtlo_mfhi();
    test_hilo_rd_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
